// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID/EX sequencing: load-use stall, branch flush, multi-cycle MDU wait
//
// Ports:
//   clk, rst            pipeline clock; asynchronous active-low reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_use_rs/rt        ID instruction actually reads rs / rt
//   id_mdu_op           ID instruction is a multi-cycle mult/div
//   ex_MemRead, ex_rt   load in EX and its destination register
//   ex_branch_taken     EX resolved a taken branch/jump
//   pc_write            PC may update
//   ifid_write          IF/ID may capture
//   ifid_flush          IF/ID loads a NOP
//   idex_bubble         ID/EX captures all-zero control
//   mdu_start           one-cycle pulse when an MDU op issues to EX
//   mdu_busy            high while the MDU op holds the issue slot
//   stall_cnt           saturating count of cycles with pc_write low
module hazard_stall_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_mdu_op,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1
    } state_t;

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] mdu_cnt;
    logic             load_use;

    // r0 is never a real dependency, so a load to r0 cannot cause a hazard.
    assign load_use = ex_MemRead & (ex_rt != 5'd0) &
                      ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));

    // Mealy outputs: decided from the current state and this cycle's inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mdu_start   = 1'b0;
        mdu_busy    = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID are discarded.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_mdu_op) begin
                    mdu_start = 1'b1;
                end
            end
            MDU_WAIT: begin
                // EX is occupied by the MDU op; everything upstream holds.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                mdu_busy    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            mdu_cnt   <= '0;
            stall_cnt <= 16'd0;
        end else begin
            if (!pc_write && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            case (state)
                RUN: begin
                    if (mdu_start) begin
                        state   <= MDU_WAIT;
                        mdu_cnt <= MDU_LOAD;
                    end
                end
                MDU_WAIT: begin
                    // A zero count here can only come from corruption; leave as well.
                    if (mdu_cnt <= CNT_ONE) begin
                        state   <= RUN;
                        mdu_cnt <= '0;
                    end else begin
                        mdu_cnt <= mdu_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state   <= RUN;
                    mdu_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int MDU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, id_mdu_op, ex_MemRead, ex_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, mdu_start, mdu_busy;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Model state: stall cycles still owed to an in-flight MDU op, and the log count.
    int m_wait = 0;
    int m_cnt  = 0;

    typedef struct packed {
        logic pcw;
        logic ifw;
        logic fl;
        logic bub;
        logic st;
        logic busy;
    } outs_t;

    hazard_stall_ctrl #(.MDU_CYCLES(MDU), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu_op(id_mdu_op), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic outs_t expect_outs(input int wait_left, input logic r);
        outs_t o;
        logic  hazard;
        o = '{pcw: 1'b1, ifw: 1'b1, fl: 1'b0, bub: 1'b0, st: 1'b0, busy: 1'b0};
        hazard = 1'b0;
        if (ex_MemRead && ex_rt != 0) begin
            if (id_use_rs && id_rs == ex_rt) hazard = 1'b1;
            if (id_use_rt && id_rt == ex_rt) hazard = 1'b1;
        end
        if (!r) return o;
        if (wait_left > 0) begin
            o.pcw = 1'b0; o.ifw = 1'b0; o.bub = 1'b1; o.busy = 1'b1;
        end else if (ex_branch_taken) begin
            o.fl = 1'b1; o.bub = 1'b1;
        end else if (hazard) begin
            o.pcw = 1'b0; o.ifw = 1'b0; o.bub = 1'b1;
        end else if (id_mdu_op) begin
            o.st = 1'b1;
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        outs_t o;
        if (!rst) begin
            m_wait <= 0;
            m_cnt  <= 0;
        end else begin
            o = expect_outs(m_wait, rst);
            if (o.st) m_wait <= MDU - 1;
            else if (m_wait > 0) m_wait <= m_wait - 1;
            if (!o.pcw && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    task automatic cycle_check();
        outs_t e, a;
        e = expect_outs(m_wait, rst);
        a = '{pcw: pc_write, ifw: ifid_write, fl: ifid_flush, bub: idex_bubble,
              st: mdu_start, busy: mdu_busy};
        tests++;
        if (a !== e || stall_cnt !== 16'(m_cnt)) begin
            fails++;
            $display("FAIL cycle@%0t outs{pcw,ifw,fl,bub,st,busy} got %b want %b, stall_cnt got %0d want %0d",
                     $time, a, e, stall_cnt, m_cnt);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_mdu_op = 1'b0; ex_MemRead = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step();
        chk("reset_pc_write", 32'(pc_write), 32'd1);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        step();

        // Load-use on rs.
        ex_MemRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1;
        chk("lu_pc_write", 32'(pc_write), 32'd0);
        chk("lu_ifid_write", 32'(ifid_write), 32'd0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        step();
        idle();
        #1;
        chk("lu_after_pc_write", 32'(pc_write), 32'd1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step();

        // No hazard: load to r0, then rs not actually read.
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1;
        chk("r0_no_stall", 32'(pc_write), 32'd1);
        step();
        ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
        #1;
        chk("unused_rs_no_stall", 32'(pc_write), 32'd1);
        step();
        // Hazard via rt.
        id_rt = 5'd9; id_use_rt = 1'b1; ex_rt = 5'd9;
        #1;
        chk("rt_hazard_stall", 32'(pc_write), 32'd0);
        step();
        idle();
        #1;
        chk("stall_cnt_after_rt", 32'(stall_cnt), 32'd2);

        // MDU op: start at T, busy T+1..T+3, RUN at T+4.
        id_mdu_op = 1'b1;
        #1;
        chk("mdu_start_T", 32'(mdu_start), 32'd1);
        step();
        id_mdu_op = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("mdu_busy_wait", 32'(mdu_busy), 32'd1);
            chk("mdu_pc_write_wait", 32'(pc_write), 32'd0);
            step();
        end
        #1;
        chk("mdu_done_busy", 32'(mdu_busy), 32'd0);
        chk("mdu_stall_cnt", 32'(stall_cnt), 32'd5);

        // MDU op deferred by a load-use stall, then a branch ignored during the wait.
        ex_MemRead = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1; id_mdu_op = 1'b1;
        #1;
        chk("deferred_no_start", 32'(mdu_start), 32'd0);
        step();
        ex_MemRead = 1'b0;
        #1;
        chk("deferred_start", 32'(mdu_start), 32'd1);
        step();
        id_mdu_op = 1'b0; ex_branch_taken = 1'b1;
        #1;
        chk("wait_ignores_branch", 32'(ifid_flush), 32'd0);
        step();
        ex_branch_taken = 1'b0;
        step();
        step();
        #1;
        chk("deferred_stall_cnt", 32'(stall_cnt), 32'd9);

        // Branch beats load-use and MDU issue.
        ex_branch_taken = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd4; id_rt = 5'd4;
        id_use_rt = 1'b1; id_mdu_op = 1'b1;
        #1;
        chk("br_flush", 32'(ifid_flush), 32'd1);
        chk("br_bubble", 32'(idex_bubble), 32'd1);
        chk("br_pc_write", 32'(pc_write), 32'd1);
        chk("br_no_start", 32'(mdu_start), 32'd0);
        step();
        idle();
        #1;
        chk("br_stall_cnt", 32'(stall_cnt), 32'd9);
        chk("br_no_busy", 32'(mdu_busy), 32'd0);

        // Async reset in the middle of an MDU wait.
        id_mdu_op = 1'b1;
        step();
        id_mdu_op = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(mdu_busy), 32'd0);
        chk("rst_mid_pc_write", 32'(pc_write), 32'd1);
        chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst = 1'b1;
        step();
        #1;
        chk("rst_release_busy", 32'(mdu_busy), 32'd0);
        chk("rst_release_start", 32'(mdu_start), 32'd0);
        chk("rst_release_cnt", 32'(stall_cnt), 32'd0);

        // Continuous load-use: counter saturates without wrapping.
        ex_MemRead = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
        for (int k = 0; k < 70000; k++) step();
        #1;
        chk("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
        step();
        idle();
        #1;
        chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
